// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream checker: FSM state encoding,
// backpressure LFSR polynomial/seed and the ready-density decision.
package stream_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;
    localparam logic [7:0]  RDY_ALWAYS        = 8'hFF;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
    endfunction

    function automatic logic rdy_decide(input logic [15:0] lfsr, input logic [7:0] thr);
        return (thr == RDY_ALWAYS) || (lfsr[7:0] < thr);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable.
// Used to pseudo-randomly throttle the checker's ready signal.
module lfsr16
    import stream_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            r_q <= lfsr_seed_fix(seed);
        end else if (en) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/stream_chk.sv
// Valid/ready stream checker: consumes i_len beats under LFSR backpressure and
// compares each accepted beat against an incrementing data/info sequence.
module stream_chk
    import stream_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int INFO_WIDTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [DATA_WIDTH-1:0] i_base,
    input  logic [15:0]           i_seed,
    input  logic [7:0]            i_rdy_thr,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [INFO_WIDTH-1:0] i_info,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_beat_cnt,
    output logic [LEN_WIDTH-1:0]  o_err_cnt,
    output logic [DATA_WIDTH-1:0] o_first_bad
);

    state_t                r_state;
    logic                  r_rdy;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_err_cnt;
    logic [DATA_WIDTH-1:0] r_first_bad;
    logic [DATA_WIDTH-1:0] r_exp_data;
    logic [INFO_WIDTH-1:0] r_exp_info;

    logic [15:0]           w_lfsr_q;
    logic                  w_lfsr_load;
    logic                  w_lfsr_en;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_mismatch;
    logic                  w_rdy_first;
    logic                  w_rdy_run;
    logic [LEN_WIDTH-1:0]  w_beat_nxt;

    assign w_lfsr_load = (r_state == ST_IDLE) && i_start;
    assign w_lfsr_en   = (r_state == ST_RUN);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .seed  (i_seed),
        .en    (w_lfsr_en),
        .q     (w_lfsr_q)
    );

    // NOTE: o_rdy is a flop, so its value for the next cycle is decided from
    // the LFSR value that will be current then (the seed on start, otherwise
    // the stepped value), keeping i_vld out of the ready path.
    assign w_rdy_first = rdy_decide(lfsr_seed_fix(i_seed), i_rdy_thr);
    assign w_rdy_run   = rdy_decide(lfsr_step(w_lfsr_q), i_rdy_thr);

    assign w_accept    = r_rdy && i_vld;
    assign w_beat_nxt  = r_beat_cnt + LEN_WIDTH'(1);
    assign w_last      = w_accept && (w_beat_nxt == r_len);
    assign w_mismatch  = (i_data != r_exp_data) || (i_info != r_exp_info);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_bad <= '0;
            r_exp_data  <= '0;
            r_exp_info  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rdy  <= 1'b0;
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_len       <= i_len;
                        r_beat_cnt  <= '0;
                        r_err_cnt   <= '0;
                        r_first_bad <= '0;
                        r_exp_data  <= i_base;
                        r_exp_info  <= '0;
                        if (i_len != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_rdy   <= w_rdy_first;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_beat_nxt;
                        r_exp_data <= r_exp_data + DATA_WIDTH'(1);
                        r_exp_info <= r_exp_info + INFO_WIDTH'(1);
                        if (w_mismatch) begin
                            // An err_cnt of zero means this is the run's first mismatch
                            if (r_err_cnt == '0) begin
                                r_first_bad <= i_data;
                            end
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + LEN_WIDTH'(1);
                            end
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_rdy   <= w_rdy_run;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_rdy   <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdy       = r_rdy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_beat_cnt  = r_beat_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_first_bad = r_first_bad;

endmodule

// File: tb/tb_stream_chk.sv
// Self-checking bench for stream_chk: randomized source against a reference
// model of the expected sequence and of the LFSR-driven ready pattern.
module tb_stream_chk;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int LW = 16;
    localparam int BUDGET = 5000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic [DW-1:0] i_base = '0;
    logic [15:0]   i_seed = '0;
    logic [7:0]    i_rdy_thr = '0;
    logic          i_vld = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [IW-1:0] i_info = '0;
    logic          o_rdy;
    logic          o_busy;
    logic          o_done;
    logic [LW-1:0] o_beat_cnt;
    logic [LW-1:0] o_err_cnt;
    logic [DW-1:0] o_first_bad;

    int errors = 0;
    int checks = 0;

    // Observations recorded by drive_run
    int            acc_cnt;
    int            done_cnt;
    int            done_cycle;
    int            rdy_bad;
    int            rdy_low;
    int            busy_cycles;
    logic [DW-1:0] acc_data[$];
    logic [IW-1:0] acc_info[$];

    stream_chk #(.DATA_WIDTH(DW), .INFO_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_base      (i_base),
        .i_seed      (i_seed),
        .i_rdy_thr   (i_rdy_thr),
        .i_vld       (i_vld),
        .o_rdy       (o_rdy),
        .i_data      (i_data),
        .i_info      (i_info),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_beat_cnt  (o_beat_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_first_bad (o_first_bad)
    );

    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1, shifted toward the MSB.
    function automatic logic [15:0] model_lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Beat i should carry base+i and tag i; count and locate the ones that do not.
    function automatic void model_errs(input logic [DW-1:0] base, output int e,
                                       output logic [DW-1:0] fb);
        logic [DW-1:0] exp_d;
        logic [IW-1:0] exp_i;
        e  = 0;
        fb = '0;
        for (int i = 0; i < acc_data.size(); i++) begin
            exp_d = base + DW'(i);
            exp_i = IW'(i);
            if (acc_data[i] !== exp_d || acc_info[i] !== exp_i) begin
                if (e == 0) fb = acc_data[i];
                e++;
            end
        end
    endfunction

    // Starts a run at a negedge and plays the source until shortly after o_done.
    task automatic drive_run(input logic [LW-1:0] len, input logic [DW-1:0] base,
                             input logic [15:0] seed, input logic [7:0] thr,
                             input int vld_pct, input int bad_idx, input logic [DW-1:0] bad_data,
                             input int corrupt_pct, input int abort_after, input int restart_at);
        logic [15:0] m_lfsr;
        logic        exp_rdy;
        acc_data.delete();
        acc_info.delete();
        acc_cnt = 0; done_cnt = 0; done_cycle = -1;
        rdy_bad = 0; rdy_low = 0; busy_cycles = 0;
        m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
        i_start = 1'b1; i_len = len; i_base = base; i_seed = seed; i_rdy_thr = thr; i_vld = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (o_busy === 1'b1) begin
                busy_cycles++;
                exp_rdy = (thr == 8'hFF) || (m_lfsr[7:0] < thr);
                if (o_rdy !== exp_rdy) rdy_bad++;
                if (o_rdy === 1'b0) rdy_low++;
                m_lfsr = model_lfsr_step(m_lfsr);
            end else if (o_rdy !== 1'b0) begin
                rdy_bad++;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (done_cycle >= 0 && cyc >= done_cycle + 2) break;
            if (abort_after >= 0 && acc_cnt == abort_after) break;
            if (cyc == restart_at) begin
                i_start = 1'b1;
                i_len   = LW'(7);
            end else begin
                i_start = 1'b0;
            end
            i_vld = ($urandom_range(99) < vld_pct);
            if (i_vld) begin
                i_data = base + DW'(acc_cnt);
                i_info = IW'(acc_cnt);
                if (acc_cnt == bad_idx) begin
                    i_data = bad_data;
                end else if ($urandom_range(99) < corrupt_pct) begin
                    if ($urandom_range(1) == 1) i_data = DW'($urandom);
                    else i_info = i_info ^ IW'($urandom_range(1, 15));
                end
            end else begin
                i_data = DW'($urandom);
                i_info = IW'($urandom);
            end
            if (o_rdy === 1'b1 && i_vld) begin
                acc_data.push_back(i_data);
                acc_info.push_back(i_info);
                acc_cnt++;
            end
            @(negedge clk);
        end
        i_vld   = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b1; i_len = LW'(5); i_vld = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", o_rdy); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_beat_cnt !== '0 || o_err_cnt !== '0 || o_first_bad !== '0) begin
            errors++;
            $display("FAIL reset_counters got beat=%0d err=%0d first_bad=%h exp all 0", o_beat_cnt, o_err_cnt, o_first_bad);
        end
        rst_n = 1'b1; i_start = 1'b0; i_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive_run(LW'(4), 16'h0010, 16'h1234, 8'hFF, 100, -1, '0, 0, -1, -1);
        checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL basic_accepts got=%0d exp=4", acc_cnt); end
        checks++; if (done_cycle !== 4) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=4", done_cycle); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy_cycles !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=4", busy_cycles); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL basic_rdy_pattern got=%0d bad cycles exp=0", rdy_bad); end
        checks++; if (o_beat_cnt !== LW'(4) || o_err_cnt !== '0) begin
            errors++; $display("FAIL basic_counts got beat=%0d err=%0d exp beat=4 err=0", o_beat_cnt, o_err_cnt);
        end
    endtask

    task automatic test_wrap();
        drive_run(LW'(3), 16'hFFFE, 16'h0000, 8'hFF, 100, -1, '0, 0, -1, -1);
        checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL wrap_err got=%0d exp=0", o_err_cnt); end
        checks++; if (o_beat_cnt !== LW'(3)) begin errors++; $display("FAIL wrap_beat got=%0d exp=3", o_beat_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_mismatch();
        drive_run(LW'(5), 16'h0100, 16'h00F0, 8'hFF, 100, 2, 16'h1234, 0, -1, -1);
        checks++; if (o_err_cnt !== LW'(1)) begin errors++; $display("FAIL mismatch_err got=%0d exp=1", o_err_cnt); end
        checks++; if (o_first_bad !== 16'h1234) begin errors++; $display("FAIL mismatch_first_bad got=%h exp=1234", o_first_bad); end
        checks++; if (o_beat_cnt !== LW'(5)) begin errors++; $display("FAIL mismatch_beat got=%0d exp=5", o_beat_cnt); end
    endtask

    task automatic test_backpressure();
        drive_run(LW'(100), 16'h2000, 16'hACE1, 8'h40, 100, -1, '0, 0, -1, -1);
        checks++; if (acc_cnt !== 100) begin errors++; $display("FAIL bp_accepts got=%0d exp=100", acc_cnt); end
        checks++; if (o_beat_cnt !== LW'(100)) begin errors++; $display("FAIL bp_beat got=%0d exp=100", o_beat_cnt); end
        checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL bp_err got=%0d exp=0", o_err_cnt); end
        checks++; if (rdy_low == 0) begin errors++; $display("FAIL bp_rdy_low got=%0d low cycles exp>0", rdy_low); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL bp_rdy_pattern got=%0d bad cycles exp=0", rdy_bad); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        int busy_seen;
        drive_run(LW'(8), 16'h0300, 16'h5A5A, 8'hFF, 100, -1, '0, 0, 2, -1);
        checks++; if (o_beat_cnt !== LW'(2) || o_busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre_state got beat=%0d busy=%b exp beat=2 busy=1", o_beat_cnt, o_busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (o_rdy !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL abort_flags got rdy=%b busy=%b done=%b exp 0/0/0", o_rdy, o_busy, o_done);
        end
        checks++; if (o_beat_cnt !== '0 || o_err_cnt !== '0 || o_first_bad !== '0) begin
            errors++; $display("FAIL abort_counters got beat=%0d err=%0d first_bad=%h exp 0", o_beat_cnt, o_err_cnt, o_first_bad);
        end
        rst_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done === 1'b1) done_seen++;
            if (o_busy === 1'b1) busy_seen++;
        end
        checks++; if (done_seen !== 0 || busy_seen !== 0) begin
            errors++; $display("FAIL abort_idle got done=%0d busy=%0d cycles exp 0/0", done_seen, busy_seen);
        end
        drive_run(LW'(2), 16'h0400, 16'h0BAD, 8'hFF, 100, -1, '0, 0, -1, -1);
        checks++; if (o_beat_cnt !== LW'(2) || o_err_cnt !== '0 || done_cnt !== 1) begin
            errors++; $display("FAIL abort_rerun got beat=%0d err=%0d done=%0d exp 2/0/1", o_beat_cnt, o_err_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_len();
        drive_run(LW'(0), 16'h0500, 16'h0001, 8'hFF, 100, -1, '0, 0, -1, -1);
        checks++; if (done_cycle !== 0) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=0", done_cycle); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (acc_cnt !== 0 || busy_cycles !== 0) begin
            errors++; $display("FAIL zero_activity got accepts=%0d busy=%0d exp 0/0", acc_cnt, busy_cycles);
        end
        checks++; if (o_beat_cnt !== '0) begin errors++; $display("FAIL zero_beat_cleared got=%0d exp=0", o_beat_cnt); end
    endtask

    task automatic test_start_ignored();
        drive_run(LW'(10), 16'h0600, 16'h7777, 8'hFF, 100, -1, '0, 0, -1, 3);
        checks++; if (o_beat_cnt !== LW'(10) || acc_cnt !== 10) begin
            errors++; $display("FAIL restart_beats got beat=%0d accepts=%0d exp 10", o_beat_cnt, acc_cnt);
        end
        checks++; if (done_cycle !== 10 || done_cnt !== 1) begin
            errors++; $display("FAIL restart_done got cycle=%0d pulses=%0d exp 10/1", done_cycle, done_cnt);
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] len;
        logic [DW-1:0] base;
        logic [DW-1:0] exp_fb;
        logic [7:0]    thr;
        logic [LW-1:0] held;
        int            exp_e;
        for (int r = 0; r < 8; r++) begin
            len  = LW'($urandom_range(1, 40));
            base = DW'($urandom);
            thr  = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(8'h40, 8'hFE));
            drive_run(len, base, 16'($urandom), thr, $urandom_range(30, 100), -1, '0, 15, -1, -1);
            model_errs(base, exp_e, exp_fb);
            checks++; if (acc_cnt !== int'(len) || o_beat_cnt !== len) begin
                errors++; $display("FAIL rand%0d_beats got beat=%0d accepts=%0d exp=%0d", r, o_beat_cnt, acc_cnt, len);
            end
            checks++; if (o_err_cnt !== LW'(exp_e)) begin
                errors++; $display("FAIL rand%0d_err got=%0d exp=%0d", r, o_err_cnt, exp_e);
            end
            checks++; if (o_first_bad !== exp_fb) begin
                errors++; $display("FAIL rand%0d_first_bad got=%h exp=%h", r, o_first_bad, exp_fb);
            end
            checks++; if (rdy_bad !== 0 || done_cnt !== 1) begin
                errors++; $display("FAIL rand%0d_handshake got rdy_bad=%0d done=%0d exp 0/1", r, rdy_bad, done_cnt);
            end
        end
        held = o_beat_cnt;
        repeat (5) @(negedge clk);
        checks++; if (o_beat_cnt !== held || o_busy !== 1'b0) begin
            errors++; $display("FAIL idle_hold got beat=%0d busy=%b exp beat=%0d busy=0", o_beat_cnt, o_busy, held);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_mismatch();
        test_backpressure();
        test_reset_mid_run();
        test_zero_len();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
